// File: rtl/program_loader.sv
// Assembles big-endian 32-bit words from a UART byte stream and writes them
// to program memory with a setup/pulse/hold write sequence.
module program_loader #(
    parameter int len_addr  = 11,
    parameter int len_data  = 32,
    parameter int ram_depth = 2048
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          rx_data,
    input  logic                rx_done,
    output logic                wr,
    output logic [len_addr-1:0] addr,
    output logic [len_data-1:0] data,
    output logic                busy,
    output logic                load_done,
    output logic                overflow,
    output logic [len_addr:0]   word_count
);

    typedef enum logic [2:0] {
        IDLE, RECV, WR_SETUP, WR_PULSE, WR_HOLD, DONE
    } state_t;

    localparam logic [len_addr-1:0] last_addr = len_addr'(ram_depth - 1);

    state_t              state, state_n;
    logic [len_data-1:0] shreg, shreg_n;
    logic [1:0]          idx, idx_n;
    logic                pend, pend_n;
    logic                wr_n, busy_n, done_n, ovf_n;
    logic [len_addr-1:0] addr_n;
    logic [len_data-1:0] data_n;
    logic [len_addr:0]   cnt_n;
    logic                in_wr;
    logic [len_data-1:0] next_word;

    assign in_wr     = (state == WR_SETUP) || (state == WR_PULSE) ||
                       (state == WR_HOLD);
    assign next_word = {shreg[len_data-9:0], rx_data};

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n   = idx;
        pend_n  = pend;
        wr_n    = 1'b0;
        busy_n  = busy;
        done_n  = load_done;
        ovf_n   = overflow;
        addr_n  = addr;
        data_n  = data;
        cnt_n   = word_count;

        // Bytes keep flowing into the assembly register during writes
        if (rx_done && (state == RECV || in_wr)) begin
            shreg_n = next_word;
            idx_n   = idx + 2'd1;
            if (in_wr && idx == 2'd3)
                pend_n = 1'b1;
        end

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = RECV;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    ovf_n   = 1'b0;
                    addr_n  = '0;
                    cnt_n   = '0;
                    idx_n   = 2'd0;
                    pend_n  = 1'b0;
                end
            end
            RECV: begin
                if (pend) begin
                    data_n  = shreg;
                    pend_n  = 1'b0;
                    state_n = WR_SETUP;
                end else if (rx_done && idx == 2'd3) begin
                    data_n  = next_word;
                    state_n = WR_SETUP;
                end
            end
            WR_SETUP: begin
                state_n = WR_PULSE;
                wr_n    = 1'b1;
            end
            WR_PULSE: state_n = WR_HOLD;
            WR_HOLD: begin
                cnt_n = word_count + 1'b1;
                if (data[len_data-1 -: 6] == 6'b111111) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else if (addr == last_addr) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    ovf_n   = 1'b1;
                end else begin
                    addr_n  = addr + 1'b1;
                    state_n = RECV;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            idx        <= 2'd0;
            pend       <= 1'b0;
            wr         <= 1'b0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            overflow   <= 1'b0;
            addr       <= '0;
            data       <= '0;
            word_count <= '0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            idx        <= idx_n;
            pend       <= pend_n;
            wr         <= wr_n;
            busy       <= busy_n;
            load_done  <= done_n;
            overflow   <= ovf_n;
            addr       <= addr_n;
            data       <= data_n;
            word_count <= cnt_n;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a word-level load model and a
// per-cycle write-pulse checker.
module tb_program_loader;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        wr;
    logic [10:0] addr;
    logic [31:0] data;
    logic        busy;
    logic        load_done;
    logic        overflow;
    logic [11:0] word_count;

    program_loader #(
        .len_addr (11),
        .len_data (32),
        .ram_depth(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .wr        (wr),
        .addr      (addr),
        .data      (data),
        .busy      (busy),
        .load_done (load_done),
        .overflow  (overflow),
        .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    // Load model: word-level view of what the loader must do
    bit m_active = 0;
    bit m_done = 0;
    bit m_ovf = 0;
    int m_addr = 0;
    int m_count = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulse checker: every wr pulse must match the next expected write
    logic        prev_wr = 1'b0;
    logic [10:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic [10:0] p_addr = '0;
    logic [31:0] p_data = '0;

    always @(negedge clk) begin
        wr_t e;
        if (wr) begin
            if (prev_wr) begin
                checks++;
                errors++;
                $display("FAIL wr_width: got wr high two cycles expected one");
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr: got pulse at addr %h data %h expected none",
                         addr, data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(addr), 32'(e.a));
                chk("wr_data", data, e.d);
                chk("setup_addr", 32'(prev_addr), 32'(addr));
                chk("setup_data", prev_data, data);
            end
            p_addr = addr;
            p_data = data;
        end else if (prev_wr) begin
            chk("hold_addr", 32'(addr), 32'(p_addr));
            chk("hold_data", data, p_data);
        end
        prev_wr   = wr;
        prev_addr = addr;
        prev_data = data;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr", 32'(wr), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_data", data, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_cnt", 32'(word_count), 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        m_active = 0;
        m_done = 0;
        m_ovf = 0;
        m_addr = 0;
        m_count = 0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!m_active) begin
            m_active = 1;
            m_done = 0;
            m_ovf = 0;
            m_addr = 0;
            m_count = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic model_word(input logic [31:0] w);
        if (m_active) begin
            exp_q.push_back('{a: 11'(m_addr), d: w});
            m_count++;
            if (w[31:26] == 6'b111111) begin
                m_active = 0;
                m_done = 1;
            end else if (m_addr == DEPTH - 1) begin
                m_active = 0;
                m_done = 1;
                m_ovf = 1;
            end else begin
                m_addr++;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap,
                             input bit lat);
        model_word(w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8]);
            if (i < 3) repeat (gap) @(posedge clk);
        end
        if (lat) begin
            chk("lat_n", 32'(wr), 0);
            @(posedge clk);
            #1;
            chk("lat_n1", 32'(wr), 1);
            @(posedge clk);
            #1;
            chk("lat_n2", 32'(wr), 0);
        end
        repeat (gap) @(posedge clk);
    endtask

    task automatic check_status(string tag);
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_busy"}, 32'(busy), 32'(m_active));
        chk({tag, "_done"}, 32'(load_done), 32'(m_done));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, "_cnt"}, 32'(word_count), 32'(m_count));
        chk({tag, "_pending"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;

        do_reset();

        // Single HALT word
        do_start();
        send_word(32'hFC000000, 2, 1);
        check_status("halt1");
        chk("halt1_cnt_lit", 32'(word_count), 1);
        chk("halt1_done_lit", 32'(load_done), 1);

        // Multi-word load with an ignored start while busy
        do_start();
        send_word(32'h8C010004, 3, 1);
        do_start();
        chk("busy_start_cnt", 32'(word_count), 1);
        send_word(32'h20020005, 3, 1);
        send_word(32'hFC000000, 3, 1);
        check_status("multi");
        chk("multi_cnt_lit", 32'(word_count), 3);

        // Memory full without HALT; fifth word must not be written
        do_start();
        send_word(32'h01020304, 0, 0);
        send_word(32'h11121314, 0, 0);
        send_word(32'h21222324, 0, 0);
        send_word(32'h31323334, 0, 0);
        send_word(32'h41424344, 0, 0);
        check_status("ovf");
        chk("ovf_lit", 32'(overflow), 1);
        chk("ovf_cnt_lit", 32'(word_count), 4);
        chk("ovf_addr_lit", 32'(addr), 3);

        // Reset while the write sequence is in WR_SETUP
        do_start();
        send_byte(8'h8C);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h04);
        do_reset();
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_wr", 32'(wr), 0);
        chk("midrst_busy", 32'(busy), 0);
        do_start();
        send_word(32'hFC000000, 1, 1);
        check_status("midrst");

        // Restart from DONE
        do_start();
        chk("restart_done", 32'(load_done), 0);
        chk("restart_cnt", 32'(word_count), 0);
        chk("restart_busy", 32'(busy), 1);
        send_word(32'hFC0000AA, 2, 1);
        check_status("restart");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
